dac_tx: RTL
===========

Name: dac_tx

Overview:
- Serial audio transmitter; the playback-side counterpart of the ADC capture path.
- Accepts parallel stereo sample pairs over a valid/ready handshake into a one-pair holding register.
- Serialises each pair MSB-first in left-justified format on generated bclk/lrclk; everything runs in the dclk domain.
- Flags underrun when no pair is ready at a frame boundary.

Parameters:
- BUS_WIDTH, 16, sample width per channel.
- SLOT_BITS, 16, bit periods per channel slot; must be >= BUS_WIDTH.
- BCLK_DIV, 4, dclk cycles per bclk period; even, >= 2.

Ports:
- dclk  input  1  system/sample clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- din_l  input  BUS_WIDTH  left sample, unsigned/two's-complement agnostic.
- din_r  input  BUS_WIDTH  right sample.
- din_valid  input  1  pair on din_l/din_r is valid.
- din_ready  output  1  holding register empty; pair accepted when din_valid & din_ready.
- bclk  output  1  serial bit clock.
- lrclk  output  1  channel select: 0 = left slot, 1 = right slot.
- sdata  output  1  serial data, changes on bclk falling edge.
- underrun  output  1  one-dclk pulse: frame started with no pair available.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: bclk=0, lrclk=0, sdata=0, underrun=0, din_ready=1.
  - Internal: div_cnt=0, bit_cnt=0, holding empty, shift registers 0, state IDLE.
  - Reset mid-frame aborts the frame immediately; no partial bits resume.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps.
  - Registered bclk=1 while div_cnt is in [BCLK_DIV/2, BCLK_DIV-1], else 0.
  - tick = cycle with div_cnt==BCLK_DIV-1.
- Bit counter: on each tick bit_cnt advances modulo 2*SLOT_BITS.
  - lrclk = registered (bit_cnt >= SLOT_BITS).
  - sdata and lrclk update on the edge ending the tick cycle, coincident with bclk falling.
- Frame boundary = tick with bit_cnt==2*SLOT_BITS-1.
- Serialisation:
  - Slot bit k (0..BUS_WIDTH-1) carries sample bit BUS_WIDTH-1-k.
  - Slot bits BUS_WIDTH..SLOT_BITS-1 are 0.
  - Left slot first, then right slot.
- Holding register:
  - Written on handshake; din_ready = ~full.
  - Cleared on the frame boundary that loads it into the shift registers.
  - A handshake in the boundary cycle itself is only possible when holding was empty. The new pair goes to holding and is not used for the starting frame.
- State machine:
  - IDLE: sdata=0, no underrun; bclk/lrclk run continuously from reset release.
  - IDLE -> RUN at the first frame boundary with holding full; the pair is loaded.
  - RUN, boundary, holding full: load the pair, clear holding.
  - RUN, boundary, holding empty: transmit an all-zero frame; underrun=1 for exactly the next dclk cycle (aligned with the first bit of that frame). Remain in RUN.
  - No return to IDLE except via reset.
- Latency: a pair accepted at least one cycle before a boundary appears on sdata starting the cycle after that boundary.
- Throughput: one pair per 2*SLOT_BITS*BCLK_DIV dclk cycles. din_ready reasserts the cycle after the load.
- din_valid while din_ready=0 has no effect; the source must hold data until accepted.

Test Plan:
- Reset then idle, defaults:
  - bclk toggles with period 4 dclk; lrclk period 128 dclk.
  - sdata stays 0; underrun never pulses; din_ready=1.
- Single pair, defaults: din_l=16'hA5C3, din_r=16'h0001 accepted at cycle 1 after reset release.
  - From cycle 128, sdata bit periods read 1010010111000011 with lrclk=0.
  - Then 0000000000000001 with lrclk=1.
  - din_ready returns to 1 at cycle 129.
- Back-to-back, defaults: source presents pairs 1,2,3 with din_valid held high.
  - Each pair is accepted only when din_ready=1.
  - Frames carry 1,2,3 contiguously with no underrun.
- Underrun, defaults: after pair 1 is sent, no further data.
  - Next frame is all zeros; underrun=1 for exactly one cycle at that frame's first bit.
  - A pair supplied in the boundary cycle appears one frame later.
- Padding, BUS_WIDTH=6, SLOT_BITS=8, BCLK_DIV=2: din_l=6'b110011, din_r=6'b000001.
  - Bit periods read 11001100 | 00000100.
- Reset mid-frame: assert rst during bit 5 of the left slot.
  - All outputs go to reset values immediately.
  - After release, frame timing restarts from bit_cnt=0 in IDLE; the previously held pair is discarded.

Source files
------------

// File: rtl/dac_tx.sv
// rtl/dac_tx.sv - left-justified stereo serial audio transmitter
//
// Accepts one stereo pair at a time into a holding register and serialises it
// MSB-first on a locally generated bclk/lrclk, all in the dclk domain.
//
// Ports:
//   dclk       system clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   din_l/r    parallel left/right sample, BUS_WIDTH bits
//   din_valid  pair on din_l/din_r is valid
//   din_ready  holding register can take a pair
//   bclk       serial bit clock, BCLK_DIV dclk cycles per period
//   lrclk      slot select, 0 = left, 1 = right
//   sdata      serial data, changes with bclk falling
//   underrun   one-cycle pulse at the first bit of a frame sent without data
module dac_tx #(
  parameter int BUS_WIDTH = 16,
  parameter int SLOT_BITS = 16,
  parameter int BCLK_DIV  = 4
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] din_l,
  input  logic [BUS_WIDTH-1:0] din_r,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 underrun
);

  localparam int FRAME_W = 2 * SLOT_BITS;
  localparam int DIV_W   = $clog2(BCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_BITS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   bclk_q, bclk_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdata_q, sdata_d;
  logic                   underrun_q, underrun_d;
  logic                   ready_q, ready_d;
  logic                   full_q, full_d;
  logic [BUS_WIDTH-1:0]   hold_l_q, hold_l_d;
  logic [BUS_WIDTH-1:0]   hold_r_q, hold_r_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;

  logic                   tick;
  logic                   boundary;
  logic                   accept;
  logic                   load;
  logic [FRAME_W-1:0]     frame;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    load       = 1'b0;
    frame      = '0;

    tick     = (div_cnt_q == DIV_LAST);
    boundary = tick && (bit_cnt_q == BIT_LAST);
    accept   = din_valid && ready_q;

    if (tick) begin
      div_cnt_d = '0;
      bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
      sdata_d   = shift_q[FRAME_W-1];
      shift_d   = shift_q << 1;
    end

    if (boundary) begin
      // Frame image: each sample left-justified in its slot, pad bits zero.
      // An empty holding register yields an all-zero frame.
      if (full_q) begin
        frame[FRAME_W-1   -: BUS_WIDTH] = hold_l_q;
        frame[SLOT_BITS-1 -: BUS_WIDTH] = hold_r_q;
        load    = 1'b1;
        full_d  = 1'b0;
        state_d = RUN;
      end else if (state_q == RUN) begin
        underrun_d = 1'b1;
      end
      sdata_d = frame[FRAME_W-1];
      shift_d = frame << 1;
    end

    // Holding is empty whenever a handshake can happen here, so it never
    // collides with the load above.
    if (accept) begin
      hold_l_d = din_l;
      hold_r_d = din_r;
      full_d   = 1'b1;
    end

    // Outputs are registered from next-state so bclk, lrclk and sdata all
    // change together on the edge ending the tick cycle.
    bclk_d  = (div_cnt_d >= DIV_HALF);
    lrclk_d = (bit_cnt_d >= R_FIRST);
    // Ready stays low for the cycle right after a load.
    ready_d = ~full_d & ~load;
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b1;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      shift_q    <= shift_d;
    end
  end

  assign din_ready = ready_q;
  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;
  assign underrun  = underrun_q;

endmodule
